vga_timing_ctrl: RTL
====================

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch, pixel ticks.
REQ-003 Parameter H_SYNC, 96, hsync pulse width, pixel ticks.
REQ-004 Parameter H_BP, 48, horizontal back porch, pixel ticks.
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch, lines.
REQ-007 Parameter V_SYNC, 2, vsync pulse width, lines.
REQ-008 Parameter V_BP, 33, vertical back porch, lines.
REQ-009 Parameter SYNC_DLY, 1, pixel-tick delay on hsync/vsync/active, 0..4; matches the pixel-RAM read latency of the downstream drawing stage.
REQ-010 clk  in  1  system clock, single domain; reset is synchronous and active-high.
REQ-011 rst  in  1  synchronous active-high reset.
REQ-012 pix_en  out  1  one-clk pulse marking each pixel tick.
REQ-013 x  out  10  horizontal counter, 0..H_TOTAL-1, undelayed; drives the drawing stage's RAM address.
REQ-014 y  out  10  vertical counter, 0..V_TOTAL-1, undelayed.
REQ-015 hsync  out  1  horizontal sync, active-low, delayed SYNC_DLY ticks.
REQ-016 vsync  out  1  vertical sync, active-low, delayed SYNC_DLY ticks.
REQ-017 active  out  1  high when delayed (x,y) is inside H_ACTIVE x V_ACTIVE.
REQ-018 frame_start  out  1  one-clk pulse coincident with the pix_en where x=0,y=0 (undelayed).

Function
REQ-019 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525); both computed as localparams.
REQ-020 x increments by 1 on every clk where pix_en=1; at x=H_TOTAL-1 it wraps to 0 on the next tick.
REQ-021 y increments only on the tick where x wraps; at y=V_TOTAL-1 with x wrap, y wraps to 0.
REQ-022 Counters hold their value on clks where pix_en=0.
REQ-023 Raw hsync = 0 iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (x in 656..751 at default).
REQ-024 Raw vsync = 0 iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (y in 490..491 at default).
REQ-025 Raw active = (x < H_ACTIVE) && (y < V_ACTIVE).
REQ-026 Raw hsync/vsync/active pass through a SYNC_DLY-stage shift register advancing only on pix_en; SYNC_DLY=0 is a pure combinational pass-through.
REQ-027 x and y are registered outputs; no combinational path from rst to any output.
REQ-028 Counter widths are 10 bits; parameters with H_TOTAL or V_TOTAL > 1024 are unsupported and fail elaboration via assertion.

Reset
REQ-029 rst sampled on clk rising edge; asserted mid-line or mid-frame it takes effect on the next edge regardless of pix_en.
REQ-030 Reset values: x=0, y=0, pixel divider=0, pix_en=0, frame_start=0, hsync=1, vsync=1, active=0, all delay stages filled with (1,1,0).
REQ-031 First pix_en after reset release counts x=0,y=0 and raises frame_start.

Configuration
REQ-032 Macro VGA_CLKDIV_EN defined: internal 1-bit divider, pix_en high every second clk (50 MHz clk -> 25 MHz pixel rate), first pix_en on the second clk after rst deasserts.
REQ-033 Macro VGA_CLKDIV_EN undefined: pix_en tied to 1 outside reset (clk is already the pixel clock); counters advance every clk.

Structure
REQ-034 Package vga_pkg holds default timing constants (H_/V_ ACTIVE, FP, SYNC, BP) and a typedef coord_t = logic [9:0].
REQ-035 Sub-module vga_delay_line (parameter DEPTH, WIDTH=3, enable input) implements REQ-026; all else inline.

Verification
REQ-036 Divider off, reset release, run 800 clks -> x sequence 0..799 then 0, y steps 0->1 at the wrap, frame_start high exactly once at first tick.
REQ-037 SYNC_DLY=0: hsync low for exactly 96 ticks starting at x=656; vsync low for exactly 1600 ticks starting at y=490,x=0.
REQ-038 SYNC_DLY=1: active rises one tick after x=0,y=0 and falls one tick after x=640; no active during y>=480.
REQ-039 Full frame 420000 ticks -> exactly one frame_start per frame; x=799,y=524 followed by x=0,y=0.
REQ-040 VGA_CLKDIV_EN defined: pix_en alternates 0/1; x holds across non-tick clks; one line takes 1600 clks.
REQ-041 rst pulsed 1 clk at x=300,y=200 -> next edge x=0,y=0,hsync=1,vsync=1,active=0; counting restarts per REQ-031.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480 @ 60 Hz) and coordinate types for vga_timing_ctrl.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int COORD_W   = 10;
  localparam int COORD_MAX = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;
  // One extra bit so region bounds equal to 1024 still compare correctly.
  typedef logic [COORD_W:0]   span_t;

  typedef enum logic [1:0] {
    SYNC_IDX_ACTIVE = 2'd0,
    SYNC_IDX_VSYNC  = 2'd1,
    SYNC_IDX_HSYNC  = 2'd2
  } sync_idx_e;

  function automatic int period_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register that aligns sync/active with the pixel-RAM read latency.
module vga_delay_line #(
  parameter int               DEPTH     = 1,
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: sequential state uses <= so every stage samples its neighbour's pre-edge value;
    // the few stages here are reset explicitly, unlike a RAM, so outputs are idle from the first clk.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else if (en) begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: pixel counters, sync/active with configurable delay.
// Define VGA_CLKDIV_EN to derive the pixel tick from clk/2; otherwise clk is the pixel clock.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_DLY = 1
) (
  input  logic   clk,
  input  logic   rst,
  output logic   pix_en,
  output coord_t x,
  output coord_t y,
  output logic   hsync,
  output logic   vsync,
  output logic   active,
  output logic   frame_start
);

  localparam int H_TOTAL = period_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = period_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_total
    $error("vga_timing_ctrl: H_TOTAL/V_TOTAL exceed the 10-bit counters");
  end
  if (SYNC_DLY < 0 || SYNC_DLY > 4) begin : g_bad_dly
    $error("vga_timing_ctrl: SYNC_DLY must be 0..4");
  end

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam span_t  H_ACT    = span_t'(H_ACTIVE);
  localparam span_t  HS_BEGIN = span_t'(H_ACTIVE + H_FP);
  localparam span_t  HS_END   = span_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam span_t  V_ACT    = span_t'(V_ACTIVE);
  localparam span_t  VS_BEGIN = span_t'(V_ACTIVE + V_FP);
  localparam span_t  VS_END   = span_t'(V_ACTIVE + V_FP + V_SYNC);

  logic       tick_next;
  logic       started;
  coord_t     x_next;
  coord_t     y_next;
  span_t      x_w;
  span_t      y_w;
  logic [2:0] sync_raw;
  logic [2:0] sync_dly;

`ifdef VGA_CLKDIV_EN
  logic div;

  always_ff @(posedge clk) begin
    if (rst) div <= 1'b0;
    else     div <= ~div;
  end

  assign tick_next = div;
`else
  assign tick_next = 1'b1;
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns x_next/y_next and no latch is inferred.
    x_next = x;
    y_next = y;
    if (pix_en) begin
      if (x == H_LAST) begin
        x_next = '0;
        y_next = (y == V_LAST) ? '0 : y + coord_t'(1);
      end else begin
        x_next = x + coord_t'(1);
      end
    end
  end

  // frame_start is computed from next-state values so it lands on the same clk as its tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_en      <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      started     <= 1'b0;
    end else begin
      pix_en      <= tick_next;
      x           <= x_next;
      y           <= y_next;
      frame_start <= tick_next && (x_next == '0) && (y_next == '0);
      started     <= started | tick_next;
    end
  end

  assign x_w = {1'b0, x};
  assign y_w = {1'b0, y};

  assign sync_raw[SYNC_IDX_HSYNC]  = !((x_w >= HS_BEGIN) && (x_w < HS_END));
  assign sync_raw[SYNC_IDX_VSYNC]  = !((y_w >= VS_BEGIN) && (y_w < VS_END));
  assign sync_raw[SYNC_IDX_ACTIVE] = (x_w < H_ACT) && (y_w < V_ACT);

  vga_delay_line #(
    .DEPTH    (SYNC_DLY),
    .WIDTH    (3),
    .RESET_VAL(3'b110)
  ) u_sync_dly (
    .clk (clk),
    .rst (rst),
    .en  (pix_en),
    .din (sync_raw),
    .dout(sync_dly)
  );

  assign hsync  = sync_dly[SYNC_IDX_HSYNC];
  assign vsync  = sync_dly[SYNC_IDX_VSYNC];
  // With no delay stages, x=y=0 during reset would otherwise show active before the first tick.
  assign active = sync_dly[SYNC_IDX_ACTIVE] & started;

endmodule
